// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver with internal bit timing, mid-bit sampling, optional parity,
//   1 or 2 stop bits, and a first-word-fall-through receive FIFO whose fill
//   level drives CTS back to the remote transmitter.
//
//   State | Meaning
//   IDLE  | line idle, waiting for rx_s falling edge
//   START | timing to mid start bit, rejects glitches
//   DATA  | sampling DATA_BITS data bits, LSB first
//   PAR   | sampling the parity bit
//   STOP  | sampling STOP_BITS stop bits
//   BRK   | bad stop bit seen, waiting for line to return high
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   i_rx            asynchronous serial input, idle high
//   i_rd_en         pop FIFO head (ignored when empty)
//   i_clr_err       clears the sticky overrun flag
//   o_rd_data       FIFO head data, o_rd_perr its parity-error flag
//   o_rd_valid      FIFO not empty
//   o_fifo_count    FIFO occupancy 0..FIFO_DEPTH
//   o_cts           clear-to-send
//   o_frame_err     one-cycle pulse on a low stop bit
//   o_overrun       sticky, frame arrived while FIFO full
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8,
    parameter int CTS_MARGIN   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_rx,
    input  logic                          i_rd_en,
    input  logic                          i_clr_err,
    output logic [DATA_BITS-1:0]          o_rd_data,
    output logic                          o_rd_perr,
    output logic                          o_rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_cts,
    output logic                          o_frame_err,
    output logic                          o_overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = 4;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    // free > margin  <=>  count < depth - margin
    localparam logic [CW-1:0] CTS_LIMIT = CW'(FIFO_DEPTH - CTS_MARGIN);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_rx_meta, r_rx_s;
    logic [TW-1:0]          r_timer;
    logic [BW-1:0]          r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr;
    logic                   r_push;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   r_cts;
    logic [DATA_BITS:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]          r_count;

    logic w_full_tick, w_half_tick;
    logic w_timer_clr, w_shift_en, w_par_en, w_bit_inc, w_bit_clr;
    logic w_push_set, w_ferr_set, w_perr_clr;
    logic w_pop, w_push_ok, w_ovr_set;
    logic [CW-1:0]      w_count_nxt;
    logic [DATA_BITS:0] w_head;

    assign w_full_tick = (r_timer == TICK_FULL);
    assign w_half_tick = (r_timer == TICK_HALF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= IDLE;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_clr = 1'b0;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_bit_inc   = 1'b0;
        w_bit_clr   = 1'b0;
        w_push_set  = 1'b0;
        w_ferr_set  = 1'b0;
        w_perr_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = START;
                    w_timer_clr = 1'b1;
                    w_perr_clr  = 1'b1;
                end
            end
            START: begin
                if (w_half_tick) begin
                    w_timer_clr = 1'b1;
                    w_bit_clr   = 1'b1;
                    w_state_nxt = r_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_full_tick) begin
                    w_timer_clr = 1'b1;
                    w_shift_en  = 1'b1;
                    if (r_bit_cnt == LAST_DATA) begin
                        w_bit_clr   = 1'b1;
                        w_state_nxt = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            PAR: begin
                if (w_full_tick) begin
                    w_timer_clr = 1'b1;
                    w_par_en    = 1'b1;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_full_tick) begin
                    w_timer_clr = 1'b1;
                    if (!r_rx_s) begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = BRK;
                    end else if (r_bit_cnt == LAST_STOP) begin
                        w_push_set  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            BRK: begin
                if (r_rx_s) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Receive datapath; push and frame error are delayed one cycle after the stop sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer     <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_perr      <= 1'b0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_timer     <= w_timer_clr ? '0 : r_timer + 1'b1;
            r_push      <= w_push_set;
            r_frame_err <= w_ferr_set;
            if (w_bit_clr)      r_bit_cnt <= '0;
            else if (w_bit_inc) r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_shift_en) r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            if (w_perr_clr)    r_perr <= 1'b0;
            else if (w_par_en) r_perr <= ((^r_shift) ^ r_rx_s) != (PARITY == 1);
        end
    end

    // A pop on the same cycle frees the slot a push into a full FIFO needs.
    assign w_pop     = i_rd_en && (r_count != '0);
    assign w_push_ok = r_push && ((r_count != CNT_FULL) || w_pop);
    assign w_ovr_set = r_push && (r_count == CNT_FULL) && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop)      w_count_nxt = r_count + 1'b1;
        else if (!w_push_ok && w_pop) w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= {r_perr, r_shift};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_cts     <= 1'b1;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_cts   <= (w_count_nxt < CTS_LIMIT);
            if (w_ovr_set)      r_overrun <= 1'b1;
            else if (i_clr_err) r_overrun <= 1'b0;
        end
    end

    // Head is forced to zero when empty so stale memory never shows on the outputs.
    assign w_head       = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_rd_data    = w_head[DATA_BITS-1:0];
    assign o_rd_perr    = w_head[DATA_BITS];
    assign o_rd_valid   = (r_count != '0);
    assign o_fifo_count = r_count;
    assign o_cts        = r_cts;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_n = 1'b1, rx_e = 1'b1;
    logic       rd_en_n = 1'b0, rd_en_e = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] data_n, data_e;
    logic       perr_n, perr_e, valid_n, valid_e;
    logic [3:0] count_n, count_e;
    logic       cts_n, cts_e, ferr_n, ferr_e, ovr_n, ovr_e;

    int n_tests = 0;
    int n_fail  = 0;
    int ferr_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (ferr_n) ferr_cnt++;

    uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .FIFO_DEPTH(8), .CTS_MARGIN(2)) dut_n (
        .clk(clk), .rst(rst), .i_rx(rx_n), .i_rd_en(rd_en_n), .i_clr_err(clr_err),
        .o_rd_data(data_n), .o_rd_perr(perr_n), .o_rd_valid(valid_n),
        .o_fifo_count(count_n), .o_cts(cts_n), .o_frame_err(ferr_n), .o_overrun(ovr_n));

    uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                   .FIFO_DEPTH(8), .CTS_MARGIN(2)) dut_e (
        .clk(clk), .rst(rst), .i_rx(rx_e), .i_rd_en(rd_en_e), .i_clr_err(clr_err),
        .o_rd_data(data_e), .o_rd_perr(perr_e), .o_rd_valid(valid_e),
        .o_fifo_count(count_e), .o_cts(cts_e), .o_frame_err(ferr_e), .o_overrun(ovr_e));

    task automatic drive(input bit on_e, input logic v);
        if (on_e) rx_e = v;
        else      rx_n = v;
    endtask

    task automatic send_frame(input bit on_e, input logic [7:0] d, input bit with_par,
                              input logic par_b, input logic stop_b);
        drive(on_e, 1'b0);
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(on_e, d[i]);
            repeat (16) @(negedge clk);
        end
        if (with_par) begin
            drive(on_e, par_b);
            repeat (16) @(negedge clk);
        end
        drive(on_e, stop_b);
        repeat (16) @(negedge clk);
        drive(on_e, 1'b1);
        repeat (6) @(negedge clk);
    endtask

    task automatic pop_n();
        rd_en_n = 1'b1;
        @(negedge clk);
        rd_en_n = 1'b0;
    endtask

    task automatic pop_e();
        rd_en_e = 1'b1;
        @(negedge clk);
        rd_en_e = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (valid_n !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_n); end
        n_tests++; if (count_n !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_n); end
        n_tests++; if (data_n !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_n); end
        n_tests++; if (perr_n !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", perr_n); end
        n_tests++; if (ferr_n !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", ferr_n); end
        n_tests++; if (ovr_n !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", ovr_n); end
        n_tests++; if (cts_n !== 1'b1) begin n_fail++; $display("FAIL reset_cts: got %b want 1", cts_n); end
    endtask

    task automatic test_basic();
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        n_tests++; if (valid_n !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", valid_n); end
        n_tests++; if (data_n !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", data_n); end
        n_tests++; if (perr_n !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b want 0", perr_n); end
        n_tests++; if (count_n !== 4'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", count_n); end
        pop_n();
        n_tests++; if (count_n !== 4'd0) begin n_fail++; $display("FAIL basic_pop_count: got %0d want 0", count_n); end
        n_tests++; if (valid_n !== 1'b0) begin n_fail++; $display("FAIL basic_pop_valid: got %b want 0", valid_n); end
    endtask

    task automatic test_parity();
        // 0x07 has three ones; even parity needs parity bit 1.
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        n_tests++; if (data_e !== 8'h07) begin n_fail++; $display("FAIL par_good_data: got %h want 07", data_e); end
        n_tests++; if (perr_e !== 1'b0) begin n_fail++; $display("FAIL par_good_perr: got %b want 0", perr_e); end
        pop_e();
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        n_tests++; if (valid_e !== 1'b1) begin n_fail++; $display("FAIL par_bad_valid: got %b want 1", valid_e); end
        n_tests++; if (data_e !== 8'h07) begin n_fail++; $display("FAIL par_bad_data: got %h want 07", data_e); end
        n_tests++; if (perr_e !== 1'b1) begin n_fail++; $display("FAIL par_bad_perr: got %b want 1", perr_e); end
        pop_e();
        // 0x03: two ones, parity 0 is correct; a buggy odd/even swap flags it.
        send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        n_tests++; if (perr_e !== 1'b0) begin n_fail++; $display("FAIL par_even2_perr: got %b want 0", perr_e); end
        pop_e();
    endtask

    task automatic test_frame_err();
        ferr_cnt = 0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        n_tests++; if (ferr_cnt !== 1) begin n_fail++; $display("FAIL ferr_pulse_cycles: got %0d want 1", ferr_cnt); end
        n_tests++; if (count_n !== 4'd0) begin n_fail++; $display("FAIL ferr_count: got %0d want 0", count_n); end
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        n_tests++; if (data_n !== 8'h3C) begin n_fail++; $display("FAIL ferr_next_data: got %h want 3c", data_n); end
        n_tests++; if (count_n !== 4'd1) begin n_fail++; $display("FAIL ferr_next_count: got %0d want 1", count_n); end
        pop_n();
    endtask

    task automatic test_glitch();
        ferr_cnt = 0;
        rx_n = 1'b0;
        repeat (6) @(negedge clk);
        rx_n = 1'b1;
        repeat (40) @(negedge clk);
        n_tests++; if (count_n !== 4'd0) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", count_n); end
        n_tests++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt); end
        send_frame(1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
        n_tests++; if (data_n !== 8'h96) begin n_fail++; $display("FAIL glitch_next_data: got %h want 96", data_n); end
        pop_n();
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 9; i++) begin
            send_frame(1'b0, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
            if (i == 4) begin
                n_tests++; if (cts_n !== 1'b1) begin n_fail++; $display("FAIL ovr_cts_at5: got %b want 1", cts_n); end
            end
            if (i == 5) begin
                n_tests++; if (cts_n !== 1'b0) begin n_fail++; $display("FAIL ovr_cts_at6: got %b want 0", cts_n); end
            end
            if (i == 7) begin
                n_tests++; if (count_n !== 4'd8) begin n_fail++; $display("FAIL ovr_count_full: got %0d want 8", count_n); end
                n_tests++; if (ovr_n !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b want 0", ovr_n); end
            end
        end
        n_tests++; if (ovr_n !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", ovr_n); end
        n_tests++; if (count_n !== 4'd8) begin n_fail++; $display("FAIL ovr_count_after: got %0d want 8", count_n); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (data_n !== 8'h10 + 8'(i)) begin
                n_fail++; $display("FAIL ovr_data[%0d]: got %h want %h", i, data_n, 8'h10 + 8'(i));
            end
            pop_n();
        end
        n_tests++; if (count_n !== 4'd0) begin n_fail++; $display("FAIL ovr_drain_count: got %0d want 0", count_n); end
        n_tests++; if (ovr_n !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", ovr_n); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_tests++; if (ovr_n !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", ovr_n); end
    endtask

    task automatic test_rst_mid();
        logic [7:0] d;
        d = 8'h5A;
        send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
        rx_n = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_n = d[i];
            repeat (16) @(negedge clk);
        end
        rx_n = d[4];
        repeat (8) @(negedge clk);
        rst  = 1'b1;
        rx_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (count_n !== 4'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", count_n); end
        n_tests++; if (valid_n !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", valid_n); end
        n_tests++; if (data_n !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h want 00", data_n); end
        n_tests++; if (cts_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_cts: got %b want 1", cts_n); end
        repeat (200) @(negedge clk);
        n_tests++; if (count_n !== 4'd0) begin n_fail++; $display("FAIL rstmid_no_partial: got %0d want 0", count_n); end
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        n_tests++; if (data_n !== 8'h5A) begin n_fail++; $display("FAIL rstmid_next_data: got %h want 5a", data_n); end
        n_tests++; if (count_n !== 4'd1) begin n_fail++; $display("FAIL rstmid_next_count: got %0d want 1", count_n); end
        pop_n();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
